// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Exposes CTRL/PRESET/COUNT registers and a maskable interrupt request.
module timer_dev (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        irq
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CNT,
      ST_INT
   } state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  ctrl, ctrl_nxt;
   logic [DW-1:0]  preset, preset_nxt;
   logic [DW-1:0]  count, count_nxt;
   logic           irq_flag, flag_nxt;

   logic en;
   logic auto_reload;
   logic wr_ctrl;
   logic wr_preset;

   assign en          = ctrl[0];
   assign auto_reload = (ctrl[2:1] == 2'b01);
   assign wr_ctrl     = we && (addr == 2'd0);
   assign wr_preset   = we && (addr == 2'd1);

   // State and register file
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ctrl     <= '0;
         preset   <= '0;
         count    <= '0;
         irq_flag <= 1'b0;
      end else begin
         state    <= state_nxt;
         ctrl     <= ctrl_nxt;
         preset   <= preset_nxt;
         count    <= count_nxt;
         irq_flag <= flag_nxt;
      end
   end

   // Next-state logic; CPU writes are applied last so they override the hardware EN clear
   always_comb begin
      state_nxt  = state;
      ctrl_nxt   = ctrl;
      preset_nxt = preset;
      count_nxt  = count;
      flag_nxt   = irq_flag;

      // One-shot flag is acknowledged by any CTRL/PRESET write; a same-cycle expiry re-sets it below
      if (!auto_reload && (wr_ctrl || wr_preset)) begin
         flag_nxt = 1'b0;
      end

      case (state)
         ST_IDLE: begin
            if (en) begin
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            count_nxt = preset;
            state_nxt = ST_CNT;
         end
         ST_CNT: begin
            if (!en) begin
               state_nxt = ST_IDLE;
            end else if (count > DW'(1)) begin
               count_nxt = count - DW'(1);
            end else begin
               count_nxt = '0;
               flag_nxt  = 1'b1;
               state_nxt = ST_INT;
            end
         end
         ST_INT: begin
            if (auto_reload) begin
               flag_nxt  = 1'b0;
               state_nxt = ST_LOAD;
            end else begin
               ctrl_nxt[0] = 1'b0;
               state_nxt   = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (wr_preset) begin
         preset_nxt = wd;
      end
      if (wr_ctrl) begin
         ctrl_nxt = wd[CW-1:0];
      end
   end

   // Read mux
   always_comb begin
      rd = '0;
      case (addr)
         2'd0:    rd = DW'(ctrl);
         2'd1:    rd = preset;
         2'd2:    rd = count;
         default: rd = '0;
      endcase
   end

   assign irq = ctrl[3] & irq_flag;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed vector table, corner-case
// sequences and randomized bus traffic against a behavioural timer model.
`timescale 1ns/100ps
module tb_timer_dev;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        irq;

   int checks = 0;
   int errors = 0;

   timer_dev dut (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .addr  (addr),
      .wd    (wd),
      .rd    (rd),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Behavioural model: phase 0 idle, 1 load pending, 2 running, 3 expired
   logic [3:0]  m_ctrl;
   logic [31:0] m_preset;
   logic [31:0] m_count;
   logic        m_flag;
   int          m_phase;

   task automatic m_reset();
      m_ctrl = 4'h0; m_preset = 32'h0; m_count = 32'h0; m_flag = 1'b0; m_phase = 0;
   endtask

   task automatic m_step(input logic w, input logic [1:0] a, input logic [31:0] d);
      bit running_mode1;
      bit expired;
      running_mode1 = (m_ctrl[2:1] == 2'b01);
      expired = 1'b0;
      if (m_phase == 0) begin
         if (m_ctrl[0]) m_phase = 1;
      end else if (m_phase == 1) begin
         m_count = m_preset;
         m_phase = 2;
      end else if (m_phase == 2) begin
         if (!m_ctrl[0]) m_phase = 0;
         else if (m_count >= 2) m_count = m_count - 1;
         else begin
            m_count = 0;
            expired = 1'b1;
            m_phase = 3;
         end
      end else begin
         if (running_mode1) begin
            m_flag = 1'b0;
            m_phase = 1;
         end else begin
            m_ctrl[0] = 1'b0;
            m_phase = 0;
         end
      end
      if (w && a == 2'd1) m_preset = d;
      if (w && a == 2'd0) m_ctrl = d[3:0];
      if (w && a <= 2'd1 && !running_mode1) m_flag = 1'b0;
      if (expired) m_flag = 1'b1;
   endtask

   function automatic logic [31:0] m_rd(input logic [1:0] a);
      case (a)
         2'd0:    return {28'h0, m_ctrl};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic peek(input logic [1:0] a, output logic [31:0] v);
      we = 1'b0;
      addr = a;
      #1;
      v = rd;
   endtask

   // Compare every register and irq against the model (takes 4 ns)
   task automatic compare_all();
      logic [31:0] v;
      for (int a = 0; a < 4; a++) begin
         peek(2'(a), v);
         chk($sformatf("rd[%0d]", a), v, m_rd(2'(a)));
      end
      chk("irq", {31'h0, irq}, {31'h0, m_ctrl[3] & m_flag});
   endtask

   task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d);
      we = w; addr = a; wd = d;
      @(posedge clk);
      m_step(w, a, d);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      logic [3:0]  e_ctrl;
      logic [31:0] e_cnt;
      logic        e_irq;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [31:0] v;
      int pulses;
      int last;
      int ok;

      // One-shot, PRESET=5, CTRL=0x9: expected values after each edge
      tbl[0]  = '{1'b1, 2'd1, 32'd5, 4'h0, 32'd0, 1'b0};
      tbl[1]  = '{1'b1, 2'd0, 32'h9, 4'h9, 32'd0, 1'b0};
      tbl[2]  = '{1'b0, 2'd0, 32'h0, 4'h9, 32'd0, 1'b0};
      tbl[3]  = '{1'b0, 2'd0, 32'h0, 4'h9, 32'd5, 1'b0};
      tbl[4]  = '{1'b0, 2'd0, 32'h0, 4'h9, 32'd4, 1'b0};
      tbl[5]  = '{1'b0, 2'd0, 32'h0, 4'h9, 32'd3, 1'b0};
      tbl[6]  = '{1'b0, 2'd0, 32'h0, 4'h9, 32'd2, 1'b0};
      tbl[7]  = '{1'b0, 2'd0, 32'h0, 4'h9, 32'd1, 1'b0};
      tbl[8]  = '{1'b0, 2'd0, 32'h0, 4'h9, 32'd0, 1'b1};
      tbl[9]  = '{1'b0, 2'd0, 32'h0, 4'h8, 32'd0, 1'b1};
      tbl[10] = '{1'b0, 2'd0, 32'h0, 4'h8, 32'd0, 1'b1};
      tbl[11] = '{1'b1, 2'd0, 32'h8, 4'h8, 32'd0, 1'b0};

      we = 1'b0; addr = 2'd0; wd = 32'h0; rst_n = 1'b0;
      m_reset();
      #3;
      do_reset();

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].w, tbl[i].a, tbl[i].d);
         peek(2'd0, v); chk($sformatf("tbl%0d ctrl", i), v, {28'h0, tbl[i].e_ctrl});
         peek(2'd2, v); chk($sformatf("tbl%0d count", i), v, tbl[i].e_cnt);
         chk($sformatf("tbl%0d irq", i), {31'h0, irq}, {31'h0, tbl[i].e_irq});
      end

      // Auto-reload: one-cycle pulse every N+2 = 5 cycles, EN stays set
      do_reset();
      step(1'b1, 2'd1, 32'd3);
      step(1'b1, 2'd0, 32'hB);
      pulses = 0; last = -1; ok = 1;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 2'd0, 32'h0);
         if (irq) begin
            if (last >= 0 && i - last != 5) ok = 0;
            last = i;
            pulses++;
         end
      end
      chk("reload pulses", 32'(pulses), 32'd4);
      chk("reload spacing", 32'(ok), 32'd1);
      peek(2'd0, v); chk("reload ctrl", v, 32'hB);

      // Masked one-shot: expiry clears EN but irq stays low
      do_reset();
      step(1'b1, 2'd1, 32'd2);
      step(1'b1, 2'd0, 32'h1);
      idle(6);
      peek(2'd0, v); chk("mask ctrl", v, 32'h0);
      step(1'b1, 2'd0, 32'h8);
      chk("mask irq after unmask", {31'h0, irq}, 32'h0);

      // Pause and resume
      do_reset();
      step(1'b1, 2'd0, 32'h9);
      step(1'b1, 2'd1, 32'd10);
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (m_count == 32'd7 && m_phase == 2) ok = 1;
         else step(1'b0, 2'd0, 32'h0);
      end
      chk("pause reached 7", 32'(ok), 32'd1);
      step(1'b1, 2'd0, 32'h8);
      idle(3);
      peek(2'd2, v); chk("pause hold", v, 32'd6);
      step(1'b1, 2'd0, 32'h9);
      idle(2);
      peek(2'd2, v); chk("resume reload", v, 32'd10);

      // PRESET=0 expires like PRESET=1
      do_reset();
      step(1'b1, 2'd0, 32'h9);
      idle(2);
      chk("preset0 early irq", {31'h0, irq}, 32'h0);
      idle(1);
      chk("preset0 irq", {31'h0, irq}, 32'h1);
      step(1'b1, 2'd0, 32'h8);
      step(1'b1, 2'd2, 32'h1234);
      peek(2'd2, v); chk("count write ignored", v, 32'h0);
      step(1'b1, 2'd3, 32'hFFFF_FFFF);
      peek(2'd3, v); chk("addr3 reads 0", v, 32'h0);

      // PRESET write while counting leaves the running count alone
      step(1'b1, 2'd1, 32'd8);
      step(1'b1, 2'd0, 32'h9);
      idle(2);
      peek(2'd2, v); chk("count loaded", v, 32'd8);
      step(1'b1, 2'd1, 32'd3);
      peek(2'd2, v); chk("preset write in cnt", v, 32'd7);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         step(1'b0, 2'd0, 32'h0);
         if (m_flag) ok = 1;
      end
      chk("expiry before reset", 32'(ok), 32'd1);
      idle(2);
      chk("irq before reset", {31'h0, irq}, 32'h1);

      // Asynchronous reset mid-operation clears everything before the next edge
      do_reset();
      idle(3);

      // Randomized bus traffic
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 11);
         case (r)
            0, 1:    step(1'b1, 2'd0, $urandom);
            2:       step(1'b1, 2'd1, 32'($urandom_range(0, 6)));
            3:       step(1'b1, 2'd2, $urandom);
            4:       step(1'b1, 2'd3, $urandom);
            default: step(1'b0, 2'($urandom_range(0, 3)), $urandom);
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
